// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiply-accumulate back end:
// default widths, FSM state encoding and saturation limits.
package booth_pkg;

  localparam int PROD_W_DEFAULT    = 16;
  localparam int ACC_W_DEFAULT     = 24;
  localparam int MAX_TERMS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturation limits of the default-width accumulator.
  localparam logic signed [ACC_W_DEFAULT-1:0] SAT_MAX = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
  localparam logic signed [ACC_W_DEFAULT-1:0] SAT_MIN = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/booth_mac_acc_if.sv
// Product input stream, result output stream and vector abort for the
// multiply-accumulate back end. The slave modport is the accumulator's view.
interface booth_mac_acc_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 5
);

  logic                     clr;
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [PROD_W-1:0] prod_data;
  logic                     prod_last;
  logic                     acc_valid;
  logic                     acc_ready;
  logic signed [ACC_W-1:0]  acc_data;
  logic [CNT_W-1:0]         acc_count;
  logic                     acc_ovf;

  modport master (
    output clr, prod_valid, prod_data, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );

  modport slave (
    input  clr, prod_valid, prod_data, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );

endinterface

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the representable range of W
// bits and flags when clamping happened.
module sat_add #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] full;

  // One extra bit holds the exact sum; disagreement of the top two bits means
  // the true result left the W-bit range, and its sign picks the clamp value.
  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    sum  = full[W-1:0];
    ovf  = 1'b0;
    if (full[W] != full[W-1]) begin
      ovf = 1'b1;
      sum = full[W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/booth_mac_acc.sv
// Multiply-accumulate back end: sums a vector of signed Booth products into a
// saturating accumulator and hands the result downstream over valid/ready.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEFAULT,
  parameter int ACC_W     = ACC_W_DEFAULT,
  parameter int MAX_TERMS = MAX_TERMS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mac_acc_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    ovf_reg, ovf_next;
  logic                    live_reg;

  logic                    ready;
  logic                    accept;
  logic                    terminate;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;

  // live_reg keeps prod_ready low while in reset and for the reset cycle itself.
  assign ready     = live_reg && (state_reg != DONE);
  assign accept    = bus.prod_valid && ready && !bus.clr;
  assign prod_ext  = ACC_W'(bus.prod_data);
  assign terminate = bus.prod_last ||
                     (state_reg == IDLE  && MAX_TERMS == 1) ||
                     (state_reg == ACCUM && cnt_reg == CNT_W'(MAX_TERMS - 1));

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_reg),
    .b   (prod_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  // State register plus the live flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
    end
  end

  // Next-state: terminating product closes the vector; handshake reopens it.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = terminate ? DONE : ACCUM;
      ACCUM:   if (accept && terminate) state_next = DONE;
      DONE:    if (bus.acc_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.clr) state_next = IDLE;
  end

  // Outputs decoded from state and the result registers.
  always_comb begin
    bus.prod_ready = ready;
    bus.acc_valid  = (state_reg == DONE);
    bus.acc_data   = acc_reg;
    bus.acc_count  = cnt_reg;
    bus.acc_ovf    = ovf_reg;
  end

  // Datapath next values: first product loads, later ones saturate-add,
  // abort or delivered result clears everything.
  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (bus.clr) begin
      acc_next = '0;
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (accept) begin
      if (state_reg == IDLE) begin
        acc_next = prod_ext;
        cnt_next = CNT_W'(1);
        ovf_next = 1'b0;
      end else begin
        acc_next = sum;
        cnt_next = cnt_reg + CNT_W'(1);
        ovf_next = ovf_reg | add_ovf;
      end
    end else if (state_reg == DONE && bus.acc_ready) begin
      acc_next = '0;
      cnt_next = '0;
      ovf_next = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
    end
  end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Scoreboard bench for booth_mac_acc: a vector-level reference model queues
// expected results, a negedge monitor compares whatever the DUT presents.
module tb_booth_mac_acc;

  localparam int PROD_W    = 16;
  localparam int ACC_W     = 16;
  localparam int MAX_TERMS = 4;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);

  typedef struct {
    longint data;
    int     count;
    bit     ovf;
  } result_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  booth_mac_acc_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) mac_if ();

  booth_mac_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mac_if)
  );

  always #5 clk = ~clk;

  result_t exp_q[$];
  longint  vec[$];
  bit      pending      = 1'b0;
  bit      alive        = 1'b0;
  bit      accepted_evt = 1'b0;
  bit      rand_ready   = 1'b0;
  bit      ready_hold   = 1'b1;
  int      checks       = 0;
  int      errors       = 0;

  // Reference: sum the terms in order, clamping each partial sum.
  function automatic result_t reduce(input longint terms[$]);
    result_t r;
    longint hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    longint lo = -(longint'(1) <<< (ACC_W - 1));
    longint s;
    r.data = 0;
    r.ovf  = 1'b0;
    foreach (terms[i]) begin
      s = r.data + terms[i];
      if (s > hi) begin s = hi; r.ovf = 1'b1; end
      else if (s < lo) begin s = lo; r.ovf = 1'b1; end
      r.data = s;
    end
    r.count = terms.size();
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks vector contents and whether a result is pending.
  always @(posedge clk) begin
    accepted_evt = 1'b0;
    if (!rst_n) begin
      vec.delete();
      exp_q.delete();
      pending = 1'b0;
      alive   = 1'b0;
    end else begin
      if (mac_if.clr) begin
        vec.delete();
        if (pending) exp_q.delete();
        pending = 1'b0;
      end else if (pending) begin
        if (mac_if.acc_ready) pending = 1'b0;
      end else if (alive && mac_if.prod_valid) begin
        accepted_evt = 1'b1;
        vec.push_back(longint'(mac_if.prod_data));
        if (mac_if.prod_last || vec.size() == MAX_TERMS) begin
          exp_q.push_back(reduce(vec));
          vec.delete();
          pending = 1'b1;
        end
      end
      alive = 1'b1;
    end
  end

  // Monitor: compares handshake flags every cycle and results while valid.
  always @(negedge clk) begin
    result_t e;
    check("prod_ready", longint'(mac_if.prod_ready), longint'(alive && !pending));
    check("acc_valid", longint'(mac_if.acc_valid), longint'(exp_q.size() != 0));
    if (mac_if.acc_valid && exp_q.size() != 0) begin
      e = exp_q[0];
      check("acc_data", longint'(mac_if.acc_data), e.data);
      check("acc_count", longint'(mac_if.acc_count), longint'(e.count));
      check("acc_ovf", longint'(mac_if.acc_ovf), longint'(e.ovf));
      if (mac_if.acc_ready && rst_n && !mac_if.clr) begin
        void'(exp_q.pop_front());
        $display("result data=%0d count=%0d ovf=%0d", e.data, e.count, e.ovf);
      end
    end else if (!mac_if.acc_valid && vec.size() == 0) begin
      check("idle_data", longint'(mac_if.acc_data), 0);
      check("idle_count", longint'(mac_if.acc_count), 0);
      check("idle_ovf", longint'(mac_if.acc_ovf), 0);
    end
  end

  // Downstream ready: either held by the sequence or randomised per cycle.
  always @(posedge clk) begin
    #2;
    mac_if.acc_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
  end

  task automatic send(input longint d, input bit last);
    int n = 0;
    mac_if.prod_valid = 1'b1;
    mac_if.prod_data  = PROD_W'(d);
    mac_if.prod_last  = last;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!accepted_evt && n < 200);
    if (!accepted_evt) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: product %0d not accepted, expected acceptance", d);
    end
    mac_if.prod_valid = 1'b0;
    mac_if.prod_last  = 1'b0;
  endtask

  task automatic do_clr(input bit with_prod);
    mac_if.clr        = 1'b1;
    mac_if.prod_valid = with_prod;
    mac_if.prod_data  = PROD_W'(100);
    @(posedge clk); #1;
    mac_if.clr        = 1'b0;
    mac_if.prod_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((pending || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (pending || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: result still pending, expected delivered");
    end
  endtask

  initial begin
    mac_if.clr        = 1'b0;
    mac_if.prod_valid = 1'b0;
    mac_if.prod_data  = '0;
    mac_if.prod_last  = 1'b0;
    mac_if.acc_ready  = 1'b0;

    // Reset for three clocks.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain dot product.
    ready_hold = 1'b1;
    send(12, 0); send(-35, 0); send(16384, 1);
    wait_drain();

    // Backpressure: result held while a product is offered and refused.
    ready_hold = 1'b0;
    @(posedge clk); #1;
    send(12, 0); send(-35, 0); send(16384, 1);
    mac_if.prod_valid = 1'b1;
    mac_if.prod_data  = PROD_W'(99);
    repeat (5) begin @(posedge clk); #1; end
    ready_hold = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mac_if.prod_valid = 1'b0;
    wait_drain();

    // Positive and negative saturation.
    send(16384, 0); send(16384, 0); send(16384, 1);
    wait_drain();
    send(-16256, 0); send(-16256, 0); send(-16256, 1);
    wait_drain();

    // Abort mid-vector, then a one-term vector.
    send(7, 0); send(8, 0);
    do_clr(1'b1);
    @(posedge clk); #1;
    send(5, 1);
    wait_drain();

    // Term limit: fifth product waits for the handshake, opens a new vector.
    repeat (5) send(1, 0);
    send(0, 1);
    wait_drain();

    // Abort while a result is waiting.
    ready_hold = 1'b0;
    @(posedge clk); #1;
    send(3, 1);
    @(posedge clk); #1;
    do_clr(1'b0);
    ready_hold = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      longint d;
      if ($urandom_range(0, 1) == 0) d = longint'($urandom_range(0, 200)) - 100;
      else d = longint'($signed(PROD_W'($urandom)));
      if ($urandom_range(0, 29) == 0) do_clr(1'($urandom_range(0, 1)));
      send(d, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    send(1, 1);
    rand_ready = 1'b0;
    ready_hold = 1'b1;
    @(posedge clk); #1;
    wait_drain();
    repeat (3) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
